// File: rtl/muxn_pkg.sv
// Shared types and helpers for the mux_n_seq tap selector.
package muxn_pkg;

  localparam int unsigned MUXN_MAX_IN = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Limit a requested last-tap index to the highest existing lane.
  function automatic int unsigned clamp_idx(input int unsigned idx, input int unsigned num_in);
    return (idx > num_in - 1) ? num_in - 1 : idx;
  endfunction

endpackage

// File: rtl/muxn_comb.sv
// Combinational NUM_IN:1 lane select; an index with no matching lane gives zero and raises o_err.
module muxn_comb #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 11,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_data,
  input  logic [SEL_WIDTH-1:0]         i_idx,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_err
);

  always_comb begin
    o_data = '0;
    o_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (i_idx == SEL_WIDTH'(k)) begin
        o_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_seq.sv
// Registered N:1 tap selector with direct and sequence modes, valid/ready on both sides.
// Optional build macro MUXN_ZERO_SKIP_EN skips all-zero non-final taps and adds skip_cnt.
module mux_n_seq
  import muxn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 11,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic                         mode_seq,
  input  logic                         start,
  input  logic [SEL_WIDTH-1:0]         seq_last,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         out_err,
  output logic                         busy
`ifdef MUXN_ZERO_SKIP_EN
  ,
  output logic [SEL_WIDTH:0]           skip_cnt
`endif
);

  if (NUM_IN < 2 || NUM_IN > MUXN_MAX_IN) begin : g_bad_num_in
    $error("mux_n_seq: NUM_IN out of supported range");
  end

  state_e                r_state, w_state_d;
  logic [SEL_WIDTH-1:0]  r_idx, w_idx_d;
  logic [SEL_WIDTH-1:0]  r_last_q, w_last_d;
  logic [SEL_WIDTH-1:0]  w_mux_idx;
  logic [DATA_WIDTH-1:0] w_mux_data;
  logic                  w_mux_err;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid, r_out_last, r_out_err;
  logic                  w_in_ready, w_fire, w_skip, w_is_last;

  assign w_in_ready = ~r_out_valid | out_ready;
  assign w_is_last  = (r_idx == r_last_q);
  // One shared selector: the counter drives it in RUN, the direct select otherwise.
  assign w_mux_idx  = (r_state == RUN) ? r_idx : sel;

  muxn_comb #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_IN    (NUM_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_muxn_comb (
    .i_data(in_data),
    .i_idx (w_mux_idx),
    .o_data(w_mux_data),
    .o_err (w_mux_err)
  );

`ifdef MUXN_ZERO_SKIP_EN
  // A skip needs only in_valid; the final tap is always issued so out_last survives.
  assign w_skip = (r_state == RUN) & in_valid & (w_mux_data == '0) & ~w_is_last;
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_last_d  = r_last_q;
    w_fire    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!mode_seq) begin
          w_fire = in_valid & w_in_ready;
        end else if (start) begin
          w_idx_d   = '0;
          w_last_d  = SEL_WIDTH'(clamp_idx(32'(seq_last), NUM_IN));
          w_state_d = RUN;
        end
      end
      RUN: begin
        if (w_skip) begin
          w_idx_d = r_idx + 1'b1;
        end else if (in_valid & w_in_ready) begin
          w_fire = 1'b1;
          if (w_is_last) begin
            w_idx_d   = '0;
            w_state_d = IDLE;
          end else begin
            w_idx_d = r_idx + 1'b1;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_last_q <= '0;
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_last_q <= w_last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
    end else if (w_fire) begin
      r_out_data  <= w_mux_data;
      r_out_err   <= w_mux_err;
      r_out_last  <= (r_state == RUN) & w_is_last;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MUXN_ZERO_SKIP_EN
  logic               w_start_seq;
  logic [SEL_WIDTH:0] r_skip_cnt;

  assign w_start_seq = (r_state == IDLE) & mode_seq & start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skip_cnt <= '0;
    end else if (w_start_seq) begin
      r_skip_cnt <= '0;
    end else if (w_skip) begin
      r_skip_cnt <= r_skip_cnt + 1'b1;
    end
  end

  assign skip_cnt = r_skip_cnt;
`endif

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_err   = r_out_err;
  assign busy      = (r_state == RUN);

endmodule

// File: tb/tb_mux_n_seq.sv
// Self-checking bench for mux_n_seq: behavioural model compared every cycle plus directed literals.
module tb_mux_n_seq;

  localparam int unsigned DW = 16;
  localparam int unsigned NI = 11;
  localparam int unsigned SW = $clog2(NI);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NI*DW-1:0] in_data;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [SW-1:0]    sel = '0;
  logic             mode_seq = 1'b0;
  logic             start = 1'b0;
  logic [SW-1:0]    seq_last = '0;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_last;
  logic             out_err;
  logic             busy;
`ifdef MUXN_ZERO_SKIP_EN
  logic [SW:0]      skip_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mux_n_seq #(
    .DATA_WIDTH(DW),
    .NUM_IN    (NI)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .mode_seq (mode_seq),
    .start    (start),
    .seq_last (seq_last),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .out_err  (out_err),
    .busy     (busy)
`ifdef MUXN_ZERO_SKIP_EN
    ,
    .skip_cnt (skip_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int unsigned k);
    return in_data[k*DW +: DW];
  endfunction

  // Model: sequence position, end tap, skip tally and the expected output beat.
  bit            m_busy  = 0;
  bit            m_valid = 0;
  bit            m_last  = 0;
  bit            m_err   = 0;
  logic [DW-1:0] m_data  = '0;
  int unsigned   m_pos   = 0;
  int unsigned   m_end   = 0;
  int unsigned   m_skips = 0;

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy, fire, e, l, skip_now;
    logic [DW-1:0] d;
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_last = 0; m_err = 0; m_data = '0;
      m_pos = 0; m_end = 0; m_skips = 0;
    end else begin
      rdy = !m_valid || out_ready;
      fire = 0; e = 0; l = 0; d = '0; skip_now = 0;
      if (!m_busy) begin
        if (!mode_seq) begin
          if (in_valid && rdy) begin
            fire = 1;
            if (int'(sel) < NI) d = lane(int'(sel));
            else e = 1;
          end
        end else if (start) begin
          m_busy  = 1;
          m_pos   = 0;
          m_end   = (int'(seq_last) > NI - 1) ? NI - 1 : int'(seq_last);
          m_skips = 0;
        end
      end else begin
`ifdef MUXN_ZERO_SKIP_EN
        skip_now = (lane(m_pos) == '0) && (m_pos != m_end);
`endif
        if (in_valid && skip_now) begin
          m_pos++;
          m_skips++;
        end else if (in_valid && rdy) begin
          fire = 1;
          d = lane(m_pos);
          l = (m_pos == m_end);
          if (l) begin
            m_busy = 0;
            m_pos  = 0;
          end else begin
            m_pos++;
          end
        end
      end
      if (fire) begin
        m_valid = 1; m_data = d; m_err = e; m_last = l;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(posedge clk) begin : compare
    #1;
    if (rst_n) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      check("busy", 32'(busy), 32'(m_busy));
      if (m_valid) begin
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_last", 32'(out_last), 32'(m_last));
        check("out_err", 32'(out_err), 32'(m_err));
      end
`ifdef MUXN_ZERO_SKIP_EN
      check("skip_cnt", 32'(skip_cnt), m_skips);
`endif
    end
  end

  // Beats actually handed downstream, as {last, err, data}.
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back({out_last, out_err, out_data});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_run(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), 1'b0, 16'(16'h0100 + i)});
  endtask

  task automatic check_beats(input string name);
    check({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) check(name, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((busy || out_valid) && n < budget) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy || out_valid), 0);
  endtask

  task automatic start_seq(input logic [SW-1:0] last);
    mode_seq = 1'b1;
    seq_last = last;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < NI; k++) in_data[k*DW +: DW] = 16'(16'h0100 + k);

    // Reset values
    repeat (2) step();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    step();

    // Direct mode
    sel = 4'd7; in_valid = 1'b1;
    step();
    check("dir7_data", 32'(out_data), 32'h0107);
    check("dir7_valid", 32'(out_valid), 1);
    check("dir7_err", 32'(out_err), 0);
    check("dir7_last", 32'(out_last), 0);
    sel = 4'd12;
    step();
    check("dir12_data", 32'(out_data), 0);
    check("dir12_err", 32'(out_err), 1);
    sel = 4'd3;
    step();
    check("dir3_data", 32'(out_data), 32'h0103);
    check("dir3_err", 32'(out_err), 0);
    in_valid = 1'b0;
    repeat (2) step();
    got_q.delete();

    // Plain sequence; in_valid during the start cycle must not produce a beat
    in_valid = 1'b1;
    start_seq(4'd4);
    check("seq_busy_after_start", 32'(busy), 1);
    check("seq_no_beat_at_start", 32'(out_valid), 0);
    run_until_idle(40);
    check("seq_busy_end", 32'(busy), 0);
    expect_run(5);
    check_beats("seq5");

    // Backpressure after beat 2
    start_seq(4'd4);
    n = 0;
    while (!(out_valid && out_data == 16'h0102) && n < 20) begin
      step();
      n++;
    end
    check("bp_reach_beat2", 32'(out_valid && out_data == 16'h0102), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", 32'(out_data), 32'h0102);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    run_until_idle(40);
    expect_run(5);
    check_beats("bp");

    // Clamped seq_last; start and sel changes during RUN are ignored
    start_seq(4'd15);
    repeat (3) step();
    start = 1'b1; seq_last = 4'd2; sel = 4'd5;
    step();
    start = 1'b0;
    run_until_idle(60);
    expect_run(11);
    check_beats("clamp");

    // One-beat sequence
    start_seq(4'd0);
    run_until_idle(20);
    expect_run(1);
    check_beats("single");

    // Reset mid-sequence after beat 1
    start_seq(4'd4);
    n = 0;
    while (!(out_valid && out_data == 16'h0101) && n < 20) begin
      step();
      n++;
    end
    check("mid_reach_beat1", 32'(out_valid && out_data == 16'h0101), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_last", 32'(out_last), 0);
    check("mid_rst_busy", 32'(busy), 0);
    step();
    rst_n = 1'b1;
    got_q.delete();
    step();
    start_seq(4'd4);
    run_until_idle(40);
    expect_run(5);
    check_beats("after_rst");

`ifdef MUXN_ZERO_SKIP_EN
    // Zero lanes 1 and 2 are skipped, last tap always issued
    in_data[1*DW +: DW] = '0;
    in_data[2*DW +: DW] = '0;
    start_seq(4'd3);
    run_until_idle(40);
    exp_q.push_back({1'b0, 1'b0, 16'h0100});
    exp_q.push_back({1'b1, 1'b0, 16'h0103});
    check_beats("skip");
    check("skip_cnt_final", 32'(skip_cnt), 2);
    in_data[1*DW +: DW] = 16'h0101;
    in_data[2*DW +: DW] = 16'h0102;
`endif

    in_valid = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_seq.md
Name: mux_n_seq

Overview:
- Parametrised, registered N:1 tap selector for PE/FoFIR datapaths; generalises the fixed 11-input combinational mux.
- Two modes:
  - Direct mode: sel chosen per beat.
  - Sequence mode: internal counter walks taps 0..seq_last and flags the final beat.
- Valid/ready on both sides; one-cycle registered output. Out-of-range select yields zero plus an error flag, never X.

Parameters:
- DATA_WIDTH, 16, bits per input lane.
- NUM_IN, 11, number of input lanes (legal range 2..64).
- SEL_WIDTH, $clog2(NUM_IN), select/index width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_IN*DATA_WIDTH  flattened lanes; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- sel  input  SEL_WIDTH  lane select, direct mode only.
- mode_seq  input  1  0 = direct, 1 = sequence; sampled only in IDLE.
- start  input  1  single-cycle pulse that begins a sequence.
- seq_last  input  SEL_WIDTH  last tap index of the sequence; sampled at start.
- out_data  output  DATA_WIDTH  registered selected lane.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accept.
- out_last  output  1  final beat of a sequence.
- out_err  output  1  beat used an out-of-range index.
- busy  output  1  sequence in progress.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, out_last=0, out_err=0, busy=0, idx=0, last_q=0, state=IDLE.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - A transfer occurs when in_valid & in_ready.
  - While out_valid & !out_ready, all output registers hold.
  - out_valid drops one cycle after its beat is consumed if no new transfer occurs.
- Latency: exactly 1 cycle from transfer to out_valid.
- Out-of-range handling (index >= NUM_IN): out_data=0, out_err=1 for that beat; otherwise out_err=0.
- State IDLE:
  - busy=0.
  - If mode_seq=0: each transfer captures lane[sel]; out_last=0. start is ignored.
  - If mode_seq=1 and start=1: idx<=0; last_q <= min(seq_last, NUM_IN-1); go to RUN. No beat is issued in the start cycle. A clamped seq_last does not set out_err.
  - If mode_seq=1 and start=0: no transfers; in_ready still follows the rule above, but in_valid is ignored.
- State RUN:
  - busy=1. Each transfer captures lane[idx] and sets idx<=idx+1.
  - When idx==last_q, the beat carries out_last=1; idx<=0 and state goes to IDLE.
  - start during RUN is ignored. Changes on mode_seq and sel during RUN are ignored.
  - Stalls (in_valid=0 or in_ready=0) freeze idx.
- seq_last=0: one-beat sequence with out_last=1.
- in_data is sampled on every transfer; upstream may change lanes between beats.
- Reset mid-sequence: immediate return to reset values; any partial sequence is discarded.

Optional Feature:
- Macro: MUXN_ZERO_SKIP_EN.
- Defined:
  - In RUN, a lane whose value is all-zero and is not the last tap is skipped.
  - Skipping consumes an in_valid cycle, advances idx and issues no output beat. It requires in_valid only; the output register is untouched.
  - The last tap is always issued (zero or not) so out_last is never lost.
  - Adds output skip_cnt, SEL_WIDTH+1 bits: the number of skipped taps in the current/last sequence. Cleared at start; reset value 0.
- Undefined:
  - Every tap is issued.
  - No skip_cnt port.

Decomposition:
- Package muxn_pkg:
  - state enum (IDLE, RUN).
  - MUXN_MAX_IN = 64.
  - Function for index clamp.
- Sub-module muxn_comb: purely combinational NUM_IN:1 select with zero-on-out-of-range and err output. It is instantiated once and driven by either sel or idx.
- The top holds the FSM, counter and output register.

Test Plan:
- Direct, NUM_IN=11: lanes k = 16'h0100+k, sel=7, out_ready=1 -> next cycle out_data=16'h0107, out_valid=1, out_err=0, out_last=0.
- Direct, sel=12 (out of range) -> out_data=0, out_err=1; the next beat with sel=3 gives 16'h0103, out_err=0.
- Sequence: start with seq_last=4, in_valid held 1 -> five beats 0x0100..0x0104, out_last only on 0x0104; busy=1 from the cycle after start until the cycle after the last transfer.
- Backpressure: during the sequence, hold out_ready=0 for 3 cycles after beat 2 -> out_data stays 16'h0102, in_ready=0, idx frozen; on release, beats 3 and 4 follow with no loss or duplication.
- Clamp and ignore: seq_last=15 -> 11 beats, last one 16'h010A with out_last=1; a start pulse during RUN changes nothing; seq_last=0 -> a single beat with out_last=1.
- Reset mid-RUN after beat 1 -> all outputs 0 immediately; a new start produces a sequence from idx 0.
- (MUXN_ZERO_SKIP_EN) lanes 1 and 2 = 0, seq_last=3 -> beats lane0 and lane3 only, out_last on lane3, skip_cnt=2.
